sincos_sweep_ctrl: RTL and testbench
====================================

Name: sincos_sweep_ctrl

Overview:
- Sequences the 8-bit phase counter and the two 32x256 sine/cosine SRAM tables.
- LOAD mode: accepts host table writes over a valid/ready stream and drives both SRAMs' shared port 0.
- RUN mode: preloads the counter, steps it by a programmed delta, enables port-1 reads, and flags each valid registered sine/cosine sample.
- Sits between the host config/load interface and the counter/SRAM datapath.

Parameters:
- RD_LAT, 2, cycles from a read-issue cycle (csb1=0) to its sample on the registered sine_out/cosine_out.
- CNT_W, 16, width of the sample-count register.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- cfg_start  in  1  start-sweep pulse; sampled in IDLE only
- cfg_stop  in  1  stop request; sampled in RUN only
- cfg_load_req  in  1  enter table-load mode; sampled in IDLE only
- cfg_start_phase  in  8  initial counter phase
- cfg_delta  in  4  phase step per sample
- cfg_up_dn  in  1  1 = count up, 0 = count down
- cfg_num_samples  in  CNT_W  samples per sweep; 0 = continuous
- wr_valid  in  1  table write valid
- wr_ready  out  1  table write ready
- wr_addr  in  8  table address
- wr_sin  in  32  sine word
- wr_cos  in  32  cosine word
- wr_last  in  1  final word of the load
- preload  out  1  counter preload
- pl_data  out  8  counter preload value
- up_dn  out  1  counter direction
- delta  out  4  counter step
- csb0  out  1  SRAM port-0 select, active low
- web0  out  1  SRAM port-0 write enable, active low
- wmask0  out  4  port-0 byte mask
- addr0  out  8  port-0 address
- din00  out  32  sine SRAM write data
- din01  out  32  cosine SRAM write data
- csb1  out  1  SRAM port-1 read select, active low
- sample_valid  out  1  sine_out/cosine_out hold a valid sample this cycle
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at end of a sweep
- err  out  1  one-cycle pulse when a command is ignored

Behaviour:
- States are IDLE, LOAD, PRIME, RUN and DRAIN.
- Reset (reset_n=0 at an edge), from any state and mid-operation:
  - state goes to IDLE and the read-valid shift register is cleared.
  - csb0=1, web0=1, csb1=1, preload=0, delta=0, wmask0=0, addr0=0, din0x=0, wr_ready=0, sample_valid=0, done=0, err=0.
- IDLE:
  - cfg_load_req goes to LOAD. It has priority: if it arrives together with cfg_start, load wins and err pulses.
  - cfg_start latches start_phase, delta, up_dn and num_samples, then goes to PRIME.
  - delta=0 holds the counter.
- LOAD:
  - wr_ready=1.
  - Each accepted beat (wr_valid & wr_ready) registers a write for the next cycle: csb0=0, web0=0, wmask0=4'hF, addr0=wr_addr, din00=wr_sin, din01=wr_cos.
  - With no beat accepted, csb0=web0=1 the next cycle.
  - An accepted beat with wr_last=1 drops wr_ready and returns to IDLE. Its write still issues in the first IDLE cycle.
- PRIME (1 cycle):
  - preload=1, pl_data=latched phase, csb1=1.
  - Goes to RUN; the counter holds start_phase from the next cycle.
- RUN:
  - csb1=0 and delta/up_dn are taken from the latched values. Every RUN cycle issues one read and advances the counter.
  - The counter wraps mod 256; the controller ignores the wrap.
  - The issue count increments per cycle. If num_samples!=0 and this cycle's issue is number num_samples, go to DRAIN.
  - cfg_stop goes to DRAIN after the current cycle's read issues. If stop and the count end coincide, a single DRAIN is entered.
- DRAIN:
  - csb1=1, delta=0.
  - Stays until the valid shift register is empty, then done=1 for one cycle and returns to IDLE.
- sample_valid: a RD_LAT-deep shift of (state==RUN); a read issued in cycle k gives sample_valid=1 in cycle k+RD_LAT.
- err pulses for cfg_start or cfg_load_req outside IDLE, and for cfg_stop outside RUN. These commands have no other effect.
- Port 0 is never active outside LOAD or the first post-LOAD cycle. Port 1 is never active outside RUN.

Decomposition:
- Shared package sincos_pkg holds:
  - the state enum (IDLE/LOAD/PRIME/RUN/DRAIN)
  - PHASE_W=8, DATA_W=32, MASK_W=4
  - WMASK_ALL=4'hF
- One natural sub-module, sincos_rd_pipe: the RD_LAT valid shift register with an empty flag used by DRAIN.

Test Plan:
- Load of 256 beats (addr i, sin=i, cos=~i), wr_last on addr 255:
  - each write appears one cycle after acceptance with csb0=0, web0=0, wmask0=F;
  - IDLE follows; a later sweep from 0 step 1 reads back sin=i, cos=~i.
- Sweep with start_phase=8'hFC, delta=2, up, num_samples=4:
  - PRIME sets preload=1, pl_data=FC;
  - reads at FC, FE, 00, 02;
  - sample_valid high 4 cycles, starting 2 cycles after the first RUN cycle;
  - done pulses when the pipe empties.
- Down sweep with phase=03, delta=1, num_samples=0:
  - addresses 03, 02, 01, 00, FF;
  - cfg_stop asserted in the 5th RUN cycle: 5 samples total, then done.
- cfg_start asserted in RUN, cfg_stop in IDLE, and cfg_load_req together with cfg_start in IDLE:
  - err pulses each time;
  - the simultaneous case enters LOAD.
- reset_n=0 in RUN mid-sweep and in LOAD with a write pending:
  - next cycle all outputs are at reset values, busy=0, no write issues.

Source files
------------

// File: rtl/sincos_pkg.sv
// Shared types and widths for the sine/cosine sweep controller slice.
package sincos_pkg;

  localparam int PHASE_W = 8;
  localparam int DATA_W  = 32;
  localparam int MASK_W  = 4;

  localparam logic [MASK_W-1:0] WMASK_ALL = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_PRIME = 3'd2,
    ST_RUN   = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

endpackage

// File: rtl/sincos_rd_pipe.sv
// Tracks in-flight port-1 reads: a RD_LAT-deep shift of read issues, with an
// empty flag so the controller knows when the last sample has landed.
module sincos_rd_pipe
  import sincos_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic issue,
  output logic valid,
  output logic empty
);

  logic [RD_LAT-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = (sr_q << 1) | RD_LAT'(issue);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign valid = sr_q[RD_LAT-1];
  assign empty = ~|sr_q;

endmodule

// File: rtl/sincos_sweep_ctrl.sv
// Sequencer for the phase counter and the sine/cosine SRAM pair: host table
// loads on port 0, swept reads on port 1, with sample-valid tracking.
module sincos_sweep_ctrl
  import sincos_pkg::*;
#(
  parameter int RD_LAT = 2,
  parameter int CNT_W  = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cfg_start,
  input  logic               cfg_stop,
  input  logic               cfg_load_req,
  input  logic [PHASE_W-1:0] cfg_start_phase,
  input  logic [3:0]         cfg_delta,
  input  logic               cfg_up_dn,
  input  logic [CNT_W-1:0]   cfg_num_samples,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [PHASE_W-1:0] wr_addr,
  input  logic [DATA_W-1:0]  wr_sin,
  input  logic [DATA_W-1:0]  wr_cos,
  input  logic               wr_last,
  output logic               preload,
  output logic [PHASE_W-1:0] pl_data,
  output logic               up_dn,
  output logic [3:0]         delta,
  output logic               csb0,
  output logic               web0,
  output logic [MASK_W-1:0]  wmask0,
  output logic [PHASE_W-1:0] addr0,
  output logic [DATA_W-1:0]  din00,
  output logic [DATA_W-1:0]  din01,
  output logic               csb1,
  output logic               sample_valid,
  output logic               busy,
  output logic               done,
  output logic               err
);

  state_e               state_q, state_d;
  logic [PHASE_W-1:0]   phase_q, phase_d;
  logic [3:0]           delta_q, delta_d;
  logic                 up_dn_q, up_dn_d;
  logic [CNT_W-1:0]     num_q, num_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 csb0_q, csb0_d;
  logic                 web0_q, web0_d;
  logic [MASK_W-1:0]    wmask0_q, wmask0_d;
  logic [PHASE_W-1:0]   addr0_q, addr0_d;
  logic [DATA_W-1:0]    din00_q, din00_d;
  logic [DATA_W-1:0]    din01_q, din01_d;
  logic                 err_q, err_d;

  logic in_idle, in_run, wr_accept, rd_valid, rd_empty;

  assign in_idle   = (state_q == ST_IDLE);
  assign in_run    = (state_q == ST_RUN);
  assign wr_accept = (state_q == ST_LOAD) && wr_valid;

  sincos_rd_pipe #(.RD_LAT(RD_LAT)) u_rd_pipe (
    .clk    (clk),
    .reset_n(reset_n),
    .issue  (in_run),
    .valid  (rd_valid),
    .empty  (rd_empty)
  );

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    delta_d  = delta_q;
    up_dn_d  = up_dn_q;
    num_d    = num_q;
    cnt_d    = cnt_q;
    csb0_d   = 1'b1;
    web0_d   = 1'b1;
    wmask0_d = '0;
    addr0_d  = '0;
    din00_d  = '0;
    din01_d  = '0;

    case (state_q)
      ST_IDLE: begin
        if (cfg_load_req) begin
          state_d = ST_LOAD;
        end else if (cfg_start) begin
          phase_d = cfg_start_phase;
          delta_d = cfg_delta;
          up_dn_d = cfg_up_dn;
          num_d   = cfg_num_samples;
          cnt_d   = '0;
          state_d = ST_PRIME;
        end
      end
      ST_LOAD: begin
        // The write lands one cycle after acceptance, even when it is the last beat.
        if (wr_accept) begin
          csb0_d   = 1'b0;
          web0_d   = 1'b0;
          wmask0_d = WMASK_ALL;
          addr0_d  = wr_addr;
          din00_d  = wr_sin;
          din01_d  = wr_cos;
          if (wr_last) state_d = ST_IDLE;
        end
      end
      ST_PRIME: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cfg_stop || ((num_q != '0) && (cnt_d == num_q))) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (rd_empty) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    err_d = ((cfg_start | cfg_load_req) & ~in_idle)
          | (cfg_stop & ~in_run)
          | (in_idle & cfg_load_req & cfg_start);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      phase_q  <= '0;
      delta_q  <= '0;
      up_dn_q  <= 1'b0;
      num_q    <= '0;
      cnt_q    <= '0;
      csb0_q   <= 1'b1;
      web0_q   <= 1'b1;
      wmask0_q <= '0;
      addr0_q  <= '0;
      din00_q  <= '0;
      din01_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      delta_q  <= delta_d;
      up_dn_q  <= up_dn_d;
      num_q    <= num_d;
      cnt_q    <= cnt_d;
      csb0_q   <= csb0_d;
      web0_q   <= web0_d;
      wmask0_q <= wmask0_d;
      addr0_q  <= addr0_d;
      din00_q  <= din00_d;
      din01_q  <= din01_d;
      err_q    <= err_d;
    end
  end

  assign wr_ready     = (state_q == ST_LOAD);
  assign preload      = (state_q == ST_PRIME);
  assign pl_data      = phase_q;
  assign up_dn        = up_dn_q;
  assign delta        = in_run ? delta_q : 4'd0;
  assign csb1         = ~in_run;
  assign csb0         = csb0_q;
  assign web0         = web0_q;
  assign wmask0       = wmask0_q;
  assign addr0        = addr0_q;
  assign din00        = din00_q;
  assign din01        = din01_q;
  assign sample_valid = rd_valid;
  assign busy         = ~in_idle;
  assign done         = (state_q == ST_DRAIN) && rd_empty;
  assign err          = err_q;

endmodule

// File: tb/tb_sincos_sweep_ctrl.sv
// Self-checking bench for sincos_sweep_ctrl with a behavioural counter/SRAM harness.
module tb_sincos_sweep_ctrl;

  localparam int CNT_W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset_n;
  logic             cfg_start, cfg_stop, cfg_load_req, cfg_up_dn;
  logic [7:0]       cfg_start_phase;
  logic [3:0]       cfg_delta;
  logic [CNT_W-1:0] cfg_num_samples;
  logic             wr_valid, wr_ready, wr_last;
  logic [7:0]       wr_addr;
  logic [31:0]      wr_sin, wr_cos;
  logic             preload, up_dn, csb0, web0, csb1, sample_valid, busy, done, err;
  logic [7:0]       pl_data, addr0;
  logic [3:0]       delta, wmask0;
  logic [31:0]      din00, din01;

  sincos_sweep_ctrl #(.RD_LAT(2), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_load_req(cfg_load_req),
    .cfg_start_phase(cfg_start_phase), .cfg_delta(cfg_delta), .cfg_up_dn(cfg_up_dn),
    .cfg_num_samples(cfg_num_samples),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_sin(wr_sin),
    .wr_cos(wr_cos), .wr_last(wr_last),
    .preload(preload), .pl_data(pl_data), .up_dn(up_dn), .delta(delta),
    .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din00(din00), .din01(din01),
    .csb1(csb1), .sample_valid(sample_valid), .busy(busy), .done(done), .err(err)
  );

  // Harness: the phase counter and the two SRAMs the controller drives.
  logic [7:0]  ctr, rd_addr;
  logic [31:0] mem_sin [256];
  logic [31:0] mem_cos [256];
  logic [31:0] sine_out, cosine_out;

  always @(posedge clk) begin
    if (!reset_n)     ctr <= 8'd0;
    else if (preload) ctr <= pl_data;
    else if (up_dn)   ctr <= ctr + {4'd0, delta};
    else              ctr <= ctr - {4'd0, delta};
    if (!csb0 && !web0) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask0[b]) begin
          mem_sin[addr0][b*8 +: 8] <= din00[b*8 +: 8];
          mem_cos[addr0][b*8 +: 8] <= din01[b*8 +: 8];
        end
      end
    end
    if (!csb1) rd_addr <= ctr;
    sine_out   <= mem_sin[rd_addr];
    cosine_out <= mem_cos[rd_addr];
  end

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic  start;
    logic  stop;
    logic  load;
    logic  exp_err;
    logic  exp_busy;
    logic  exp_ready;
    string name;
  } vec_t;

  vec_t vecs [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic st, input logic l);
    cfg_start    = s;
    cfg_stop     = st;
    cfg_load_req = l;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_csb0"}, 32'(csb0), 32'd1);
    checkOutput({tag, "_web0"}, 32'(web0), 32'd1);
    checkOutput({tag, "_csb1"}, 32'(csb1), 32'd1);
    checkOutput({tag, "_preload"}, 32'(preload), 32'd0);
    checkOutput({tag, "_delta"}, 32'(delta), 32'd0);
    checkOutput({tag, "_wmask0"}, 32'(wmask0), 32'd0);
    checkOutput({tag, "_addr0"}, 32'(addr0), 32'd0);
    checkOutput({tag, "_din00"}, din00, 32'd0);
    checkOutput({tag, "_din01"}, din01, 32'd0);
    checkOutput({tag, "_wr_ready"}, 32'(wr_ready), 32'd0);
    checkOutput({tag, "_sample_valid"}, 32'(sample_valid), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_err"}, 32'(err), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Full 256-entry load, sin=i and cos=~i, with random valid gaps.
  task automatic loadTable();
    int idx = 0;
    int budget = 0;
    logic acc;
    applyStimulus(1'b0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("load_enter_busy", 32'(busy), 32'd1);
    checkOutput("load_enter_ready", 32'(wr_ready), 32'd1);
    while (idx < 256 && budget < 2000) begin
      wr_valid = ($urandom_range(0, 3) != 0);
      wr_addr  = 8'(idx);
      wr_sin   = 32'(idx);
      wr_cos   = ~32'(idx);
      wr_last  = (idx == 255);
      acc      = wr_valid;
      tick();
      if (acc) begin
        checkOutput("load_csb0", 32'(csb0), 32'd0);
        checkOutput("load_web0", 32'(web0), 32'd0);
        checkOutput("load_wmask0", 32'(wmask0), 32'hF);
        checkOutput("load_addr0", 32'(addr0), 32'(idx));
        checkOutput("load_din00", din00, 32'(idx));
        checkOutput("load_din01", din01, ~32'(idx));
        checkOutput("load_ready", 32'(wr_ready), (idx == 255) ? 32'd0 : 32'd1);
        idx++;
      end else begin
        checkOutput("load_gap_csb0", 32'(csb0), 32'd1);
        checkOutput("load_gap_web0", 32'(web0), 32'd1);
      end
      budget++;
    end
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    if (idx < 256) begin
      checks++;
      errors++;
      $display("[TB] FAIL load_budget actual=%0d beats expected=256", idx);
    end
    checkOutput("load_exit_busy", 32'(busy), 32'd0);
    tick();
    checkOutput("load_after_csb0", 32'(csb0), 32'd1);
    checkOutput("load_after_web0", 32'(web0), 32'd1);
  endtask

  // One sweep checked cycle by cycle against timing derived from the sample
  // count: PRIME at t=1, reads at t=2..N+1, samples at t=4..N+3, done at t=N+4.
  task automatic runSweep(input logic [7:0] sp, input logic [3:0] dl, input logic up,
                          input logic [CNT_W-1:0] num, input int stop_at, input int poke_at);
    int n;
    int j;
    int a;
    if (num != 0 && (stop_at == 0 || stop_at > int'(num))) n = int'(num);
    else n = stop_at;
    cfg_start_phase = sp;
    cfg_delta       = dl;
    cfg_up_dn       = up;
    cfg_num_samples = num;
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    for (int t = 1; t <= n + 5; t++) begin
      checkOutput("sw_preload", 32'(preload), (t == 1) ? 32'd1 : 32'd0);
      if (t == 1) checkOutput("sw_pl_data", 32'(pl_data), 32'(sp));
      checkOutput("sw_csb1", 32'(csb1), (t >= 2 && t <= n + 1) ? 32'd0 : 32'd1);
      checkOutput("sw_delta", 32'(delta), (t >= 2 && t <= n + 1) ? 32'(dl) : 32'd0);
      if (t >= 2 && t <= n + 1) checkOutput("sw_up_dn", 32'(up_dn), 32'(up));
      checkOutput("sw_csb0", 32'(csb0), 32'd1);
      checkOutput("sw_valid", 32'(sample_valid), (t >= 4 && t <= n + 3) ? 32'd1 : 32'd0);
      checkOutput("sw_done", 32'(done), (t == n + 4) ? 32'd1 : 32'd0);
      checkOutput("sw_busy", 32'(busy), (t <= n + 4) ? 32'd1 : 32'd0);
      checkOutput("sw_err", 32'(err), (poke_at != 0 && t == poke_at + 1) ? 32'd1 : 32'd0);
      if (t >= 4 && t <= n + 3) begin
        j = t - 4;
        a = ((int'(sp) + (up ? 1 : -1) * j * int'(dl)) % 256 + 256) % 256;
        checkOutput("sw_sine", sine_out, 32'(a));
        checkOutput("sw_cosine", cosine_out, ~32'(a));
      end
      cfg_stop  = (stop_at != 0 && stop_at <= n && t == stop_at + 1);
      cfg_start = (poke_at != 0 && t == poke_at);
      tick();
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  task automatic waitIdle(input string tag);
    int budget = 0;
    while (busy && budget < 40) begin
      tick();
      budget++;
    end
    checkOutput({tag, "_idle_wait"}, 32'(busy), 32'd0);
  endtask

  task automatic exitLoad();
    wr_valid = 1'b1;
    wr_last  = 1'b1;
    wr_addr  = 8'd0;
    wr_sin   = 32'd0;
    wr_cos   = ~32'd0;
    tick();
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    cfg_start_phase = 8'd0; cfg_delta = 4'd0; cfg_up_dn = 1'b1; cfg_num_samples = '0;
    wr_valid = 1'b0; wr_addr = 8'd0; wr_sin = 32'd0; wr_cos = 32'd0; wr_last = 1'b0;
    tick();
    tick();
    checkResetState("por");
    reset_n = 1'b1;
    tick();

    loadTable();
    runSweep(8'h00, 4'd1, 1'b1, 16'd256, 0, 0);
    runSweep(8'hFC, 4'd2, 1'b1, 16'd4, 0, 0);
    runSweep(8'h03, 4'd1, 1'b0, 16'd0, 5, 0);
    runSweep(8'h20, 4'd1, 1'b1, 16'd3, 3, 0);
    runSweep(8'h10, 4'd3, 1'b1, 16'd0, 6, 3);

    vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "idle_stop"};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "idle_none"};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, "load_and_start"};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, "load_only"};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, "load_and_stop"};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "start_and_stop"};
    cfg_num_samples = 16'd1;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].start, vecs[i].stop, vecs[i].load);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput({vecs[i].name, "_err"}, 32'(err), 32'(vecs[i].exp_err));
      checkOutput({vecs[i].name, "_busy"}, 32'(busy), 32'(vecs[i].exp_busy));
      checkOutput({vecs[i].name, "_ready"}, 32'(wr_ready), 32'(vecs[i].exp_ready));
      if (vecs[i].exp_ready) exitLoad();
      else waitIdle(vecs[i].name);
      tick();
    end

    // A load request while already loading is refused but loading continues.
    applyStimulus(1'b0, 1'b0, 1'b1);
    tick();
    tick();
    checkOutput("load_in_load_err", 32'(err), 32'd1);
    checkOutput("load_in_load_ready", 32'(wr_ready), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    exitLoad();

    // Reset mid-sweep.
    cfg_start_phase = 8'h40; cfg_delta = 4'd1; cfg_up_dn = 1'b1; cfg_num_samples = '0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick(); tick(); tick();
    reset_n = 1'b0;
    tick();
    checkResetState("rst_run");
    reset_n = 1'b1;
    tick();
    checkOutput("rst_run_valid2", 32'(sample_valid), 32'd0);
    checkOutput("rst_run_busy2", 32'(busy), 32'd0);

    // Reset in LOAD with a beat being accepted on the reset edge.
    applyStimulus(1'b0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    wr_valid = 1'b1; wr_addr = 8'h55; wr_sin = 32'hDEADBEEF; wr_cos = 32'h12345678;
    reset_n = 1'b0;
    tick();
    checkResetState("rst_load");
    reset_n  = 1'b1;
    wr_valid = 1'b0;
    tick();
    checkOutput("rst_load_csb0", 32'(csb0), 32'd1);
    checkOutput("rst_load_busy", 32'(busy), 32'd0);
    runSweep(8'h54, 4'd1, 1'b1, 16'd3, 0, 0);

    // Randomized sweeps over the loaded table.
    for (int r = 0; r < 8; r++) begin
      int num_r;
      int stop_r;
      num_r  = $urandom_range(0, 8);
      stop_r = $urandom_range(0, 10);
      if (num_r == 0 && stop_r == 0) stop_r = 3;
      runSweep(8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
               CNT_W'(num_r), stop_r, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
